pc_redirect_ctrl: RTL and testbench

- Sequences all control-flow redirects into the program counter: exception, branch, jump and panic requests from pipeline stages, plus fetch and hazard stalls.
- Arbitrates simultaneous requests and defers a redirect while fetch is stalled.
- Drives the PC's exception/branch/jump/panic/stall inputs with exactly one redirect per cycle.
- Issues a multi-cycle pipeline flush after each redirect and keeps a redirect counter.

---
 rtl/pc_redirect_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates exception/branch/jump/panic redirects into the PC,
// defers a redirect while fetch is stalled, flushes IF/ID after every redirect
// and counts issued redirects with a saturating counter.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exc_req,
  input  logic [31:0]      exc_target,
  input  logic             br_req,
  input  logic [31:0]      br_target,
  input  logic             jmp_req,
  input  logic [31:0]      jmp_target,
  input  logic             panic_req,
  input  logic             fetch_stall,
  input  logic             hazard_stall,
  output logic             pc_exception,
  output logic [31:0]      pc_exception_target,
  output logic             pc_branch,
  output logic [31:0]      pc_branch_target,
  output logic             pc_jump,
  output logic [31:0]      pc_jump_target,
  output logic             pc_panic,
  output logic             pc_stall,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;
  typedef enum logic [2:0] {
    K_NONE = 3'd0, K_PANIC = 3'd1, K_JUMP = 3'd2, K_BRANCH = 3'd3, K_EXC = 3'd4
  } kind_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t            state_q, state_d;
  kind_t             pend_kind_q, pend_kind_d;
  logic [31:0]       pend_target_q, pend_target_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  kind_t             req_kind;
  logic [31:0]       req_target;
  logic              issue;
  kind_t             issue_kind;
  logic [31:0]       issue_target;
  logic              stall_raw;

  // Fixed-priority pick of the highest-ranked request this cycle
  always_comb begin
    req_kind   = K_NONE;
    req_target = '0;
    if (exc_req) begin
      req_kind   = K_EXC;
      req_target = exc_target;
    end else if (br_req) begin
      req_kind   = K_BRANCH;
      req_target = br_target;
    end else if (jmp_req) begin
      req_kind   = K_JUMP;
      req_target = jmp_target;
    end else if (panic_req) begin
      req_kind   = K_PANIC;
      req_target = '0;
    end
  end

  // Next-state, pending-register and issue decisions for the redirect sequencer
  always_comb begin
    state_d        = state_q;
    pend_kind_d    = pend_kind_q;
    pend_target_d  = pend_target_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    issue          = 1'b0;
    issue_kind     = K_NONE;
    issue_target   = '0;
    stall_raw      = fetch_stall | hazard_stall;
    case (state_q)
      IDLE: begin
        if (req_kind != K_NONE) begin
          if (!fetch_stall) begin
            issue        = 1'b1;
            issue_kind   = req_kind;
            issue_target = req_target;
            state_d      = FLUSH;
            flush_cnt_d  = FLUSH_LOAD;
          end else begin
            pend_kind_d   = req_kind;
            pend_target_d = req_target;
            state_d       = PEND;
          end
        end
      end
      PEND: begin
        stall_raw = 1'b1;
        if (!fetch_stall) begin
          issue         = 1'b1;
          issue_kind    = pend_kind_q;
          issue_target  = pend_target_q;
          pend_kind_d   = K_NONE;
          pend_target_d = '0;
          state_d       = FLUSH;
          flush_cnt_d   = FLUSH_LOAD;
        end else if (req_kind > pend_kind_q) begin
          pend_kind_d   = req_kind;
          pend_target_d = req_target;
        end
      end
      FLUSH: begin
        if (exc_req) begin
          if (!fetch_stall) begin
            issue        = 1'b1;
            issue_kind   = K_EXC;
            issue_target = exc_target;
            flush_cnt_d  = FLUSH_LOAD;
          end else begin
            pend_kind_d   = K_EXC;
            pend_target_d = exc_target;
            flush_cnt_d   = '0;
            state_d       = PEND;
          end
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q == 4'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue) begin
      stall_raw = 1'b0;
      if (!(&redirect_cnt_q)) begin
        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end
    end
  end

  // Decode the issued redirect onto the PC strobes; everything is forced low during reset
  always_comb begin
    pc_exception        = 1'b0;
    pc_exception_target = '0;
    pc_branch           = 1'b0;
    pc_branch_target    = '0;
    pc_jump             = 1'b0;
    pc_jump_target      = '0;
    pc_panic            = 1'b0;
    pc_stall            = 1'b0;
    flush               = 1'b0;
    busy                = 1'b0;
    if (!reset) begin
      pc_stall = stall_raw;
      flush    = (state_q == FLUSH);
      busy     = (state_q == FLUSH) || (state_q == PEND);
      if (issue) begin
        case (issue_kind)
          K_EXC: begin
            pc_exception        = 1'b1;
            pc_exception_target = issue_target;
          end
          K_BRANCH: begin
            pc_branch        = 1'b1;
            pc_branch_target = issue_target;
          end
          K_JUMP: begin
            pc_jump        = 1'b1;
            pc_jump_target = issue_target;
          end
          K_PANIC: pc_panic = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;

  // Sequencer state, pending redirect, flush countdown and redirect counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_kind_q    <= K_NONE;
      pend_target_q  <= '0;
      flush_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_kind_q    <= pend_kind_d;
      pend_target_q  <= pend_target_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed and random stimulus against a behavioural model
// of the redirect sequencer; a second instance with a 4-bit counter shows saturation.
module tb_pc_redirect_ctrl;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, br_req, jmp_req, panic_req, fetch_stall, hazard_stall;
  logic [31:0] exc_target, br_target, jmp_target;

  logic        pc_exception, pc_branch, pc_jump, pc_panic, pc_stall, flush, busy;
  logic [31:0] pc_exception_target, pc_branch_target, pc_jump_target;
  logic [15:0] redirect_cnt;

  logic        s_exc, s_br, s_jmp, s_pan, s_stall, s_flush, s_busy;
  logic [31:0] s_exc_t, s_br_t, s_jmp_t;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  string cur_step = "init";

  // Reference model: pending redirect, remaining flush cycles, redirects issued
  bit          m_pend;
  int          m_pkind;
  logic [31:0] m_ptgt;
  int          m_flush_left;
  int          m_count;
  bit          n_pend;
  int          n_pkind;
  logic [31:0] n_ptgt;
  int          n_flush_left;
  int          n_count;

  logic        e_exc, e_br, e_jmp, e_pan, e_stall, e_flush, e_busy;
  logic [31:0] e_exc_t, e_br_t, e_jmp_t;

  pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .exc_req(exc_req), .exc_target(exc_target),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .panic_req(panic_req), .fetch_stall(fetch_stall), .hazard_stall(hazard_stall),
    .pc_exception(pc_exception), .pc_exception_target(pc_exception_target),
    .pc_branch(pc_branch), .pc_branch_target(pc_branch_target),
    .pc_jump(pc_jump), .pc_jump_target(pc_jump_target),
    .pc_panic(pc_panic), .pc_stall(pc_stall), .flush(flush), .busy(busy),
    .redirect_cnt(redirect_cnt)
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .exc_req(exc_req), .exc_target(exc_target),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .panic_req(panic_req), .fetch_stall(fetch_stall), .hazard_stall(hazard_stall),
    .pc_exception(s_exc), .pc_exception_target(s_exc_t),
    .pc_branch(s_br), .pc_branch_target(s_br_t),
    .pc_jump(s_jmp), .pc_jump_target(s_jmp_t),
    .pc_panic(s_pan), .pc_stall(s_stall), .flush(s_flush), .busy(s_busy),
    .redirect_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  function automatic int kind_of(input logic e, input logic b, input logic j, input logic p);
    if (e) return 4;
    if (b) return 3;
    if (j) return 2;
    if (p) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] target_of(input int k);
    case (k)
      4: return exc_target;
      3: return br_target;
      2: return jmp_target;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_issue(input int k, input logic [31:0] t);
    case (k)
      4: begin e_exc = 1'b1; e_exc_t = t; end
      3: begin e_br  = 1'b1; e_br_t  = t; end
      2: begin e_jmp = 1'b1; e_jmp_t = t; end
      1: e_pan = 1'b1;
      default: ;
    endcase
    e_stall      = 1'b0;
    n_flush_left = FLUSH;
    n_count      = m_count + 1;
  endtask

  task automatic model_eval();
    int  k;
    bit  flushing;
    {e_exc, e_br, e_jmp, e_pan, e_stall, e_flush, e_busy} = '0;
    e_exc_t = '0; e_br_t = '0; e_jmp_t = '0;
    n_pend = m_pend; n_pkind = m_pkind; n_ptgt = m_ptgt;
    n_flush_left = m_flush_left; n_count = m_count;
    if (reset) begin
      n_pend = 0; n_pkind = 0; n_ptgt = '0; n_flush_left = 0; n_count = 0;
    end else if (m_pend) begin
      e_stall = 1'b1;
      e_busy  = 1'b1;
      if (!fetch_stall) begin
        model_issue(m_pkind, m_ptgt);
        n_pend = 0; n_pkind = 0; n_ptgt = '0;
      end else begin
        k = kind_of(exc_req, br_req, jmp_req, panic_req);
        if (k > m_pkind) begin
          n_pkind = k;
          n_ptgt  = target_of(k);
        end
      end
    end else begin
      flushing = (m_flush_left > 0);
      e_flush  = flushing;
      e_busy   = flushing;
      e_stall  = fetch_stall | hazard_stall;
      k = flushing ? (exc_req ? 4 : 0) : kind_of(exc_req, br_req, jmp_req, panic_req);
      if (k != 0) begin
        if (!fetch_stall) begin
          model_issue(k, target_of(k));
        end else begin
          n_pend = 1; n_pkind = k; n_ptgt = target_of(k); n_flush_left = 0;
        end
      end else if (flushing) begin
        n_flush_left = m_flush_left - 1;
      end
    end
  endtask

  task automatic model_commit();
    m_pend = n_pend; m_pkind = n_pkind; m_ptgt = n_ptgt;
    m_flush_left = n_flush_left; m_count = n_count;
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s/%s observed=%h expected=%h", cur_step, tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int cap16, cap4;
    cap16 = (m_count > 65535) ? 65535 : m_count;
    cap4  = (m_count > 15) ? 15 : m_count;
    check1("pc_exception", 32'(pc_exception), 32'(e_exc));
    check1("pc_exception_target", pc_exception_target, e_exc_t);
    check1("pc_branch", 32'(pc_branch), 32'(e_br));
    check1("pc_branch_target", pc_branch_target, e_br_t);
    check1("pc_jump", 32'(pc_jump), 32'(e_jmp));
    check1("pc_jump_target", pc_jump_target, e_jmp_t);
    check1("pc_panic", 32'(pc_panic), 32'(e_pan));
    check1("pc_stall", 32'(pc_stall), 32'(e_stall));
    check1("flush", 32'(flush), 32'(e_flush));
    check1("busy", 32'(busy), 32'(e_busy));
    check1("redirect_cnt", 32'(redirect_cnt), 32'(cap16));
    check1("redirect_cnt_w4", 32'(s_cnt), 32'(cap4));
    check1("pc_panic_w4", 32'(s_pan), 32'(e_pan));
  endtask

  task automatic applyStimulus(input logic e, input logic [31:0] et, input logic b,
                               input logic [31:0] bt, input logic j, input logic [31:0] jt,
                               input logic p, input logic fs, input logic hs);
    exc_req = e; exc_target = et; br_req = b; br_target = bt;
    jmp_req = j; jmp_target = jt; panic_req = p;
    fetch_stall = fs; hazard_stall = hs;
  endtask

  task automatic idle_inputs();
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
  endtask

  // One clock: predict, sample at the falling edge, advance the model at the rising edge
  task automatic cycle(input string step);
    cur_step = step;
    model_eval();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    m_pend = 0; m_pkind = 0; m_ptgt = '0; m_flush_left = 0; m_count = 0;
    reset = 1'b1;
    idle_inputs();
    cycle("reset");
    applyStimulus(1, 32'h3000, 0, 32'h0, 1, 32'h1400, 0, 0, 0);
    cycle("reset_with_req");
    reset = 1'b0;
    idle_inputs();
    cycle("post_reset");

    // simultaneous exception and branch
    applyStimulus(1, 32'h0000_3000, 1, 32'h1100, 0, 32'h0, 0, 0, 0);
    cycle("simul_issue");
    idle_inputs();
    cycle("simul_flush1");
    cycle("simul_flush2");
    cycle("simul_idle");

    // deferred branch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 1, 32'h1200, 0, 32'h0, 0, 1, 0);
      cycle("defer_stall");
    end
    applyStimulus(0, 32'h0, 1, 32'h1200, 0, 32'h0, 0, 0, 0);
    cycle("defer_release");
    idle_inputs();
    cycle("defer_flush1");
    cycle("defer_flush2");
    cycle("defer_idle");

    // pending override by exception, later branch ignored
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 32'h1400, 0, 1, 0);
    cycle("ovr_jump");
    applyStimulus(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0, 1, 0);
    cycle("ovr_exc");
    applyStimulus(0, 32'h0, 1, 32'h1100, 0, 32'h0, 0, 1, 1);
    cycle("ovr_br_ignored");
    idle_inputs();
    cycle("ovr_release");
    cycle("ovr_flush1");
    cycle("ovr_flush2");

    // requests during flush
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
    cycle("fl_panic");
    applyStimulus(0, 32'h0, 1, 32'h1100, 0, 32'h0, 0, 0, 1);
    cycle("fl_br_ignored");
    applyStimulus(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    cycle("fl_exc");
    idle_inputs();
    cycle("fl_ext1");
    cycle("fl_ext2");
    cycle("fl_idle");

    // asynchronous reset mid-PEND
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 32'h1400, 0, 1, 0);
    cycle("ar_pend");
    applyStimulus(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    cur_step = "ar_async";
    m_pend = 0; m_pkind = 0; m_ptgt = '0; m_flush_left = 0; m_count = 0;
    model_eval();
    checkOutput();
    @(posedge clk);
    model_commit();
    #1;
    cycle("ar_held");
    reset = 1'b0;
    idle_inputs();
    cycle("ar_idle1");
    cycle("ar_idle2");

    // 17 panic redirects to saturate the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      cycle("sat_panic");
      idle_inputs();
      cycle("sat_flush1");
      cycle("sat_flush2");
    end
    cycle("sat_hold");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0));
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
